// File: rtl/poc_fifo.sv
// -----------------------------------------------------------------------------
// poc_fifo -- printer output controller with a DEPTH-entry transmit FIFO.
//
// The CPU pushes bytes through a small register file (DATA/CTRL/STATUS/THRESH).
// A printer-service FSM drains the FIFO one entry at a time using the
// print_ready / pulse_request handshake. irq (active-low) flags a low FIFO
// level in interrupt mode, or a sticky overflow in either mode.
//
// Optional feature macro: POC_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent waiting on the printer. After
//   TIMEOUT_CYC cycles it abandons the byte, returns the FSM to IDLE and sets
//   the sticky STATUS.timeout flag. When undefined there is no watchdog,
//   STATUS bit4 reads 0 and TIMEOUT_CYC is unused.
//
// Parameters:
//   DATA_W      data / register width (>= 8)
//   DEPTH       FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC printer handshake watchdog limit (POC_TIMEOUT_EN only)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   wr_en, rd_en   CPU register write / read strobes
//   addr           register select: 0 DATA, 1 CTRL, 2 STATUS, 3 THRESH
//   wdata          CPU write data
//   rdata          registered CPU read data (holds between reads)
//   irq            registered active-low interrupt
//   print_ready    printer ready level
//   print_data     byte presented to the printer
//   pulse_request  one-cycle print strobe
// -----------------------------------------------------------------------------
module poc_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq,
  input  logic              print_ready,
  output logic [DATA_W-1:0] print_data,
  output logic              pulse_request
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Reject parameter sets the register map cannot represent (STATUS needs
  // bit7, THRESH/level must fit in a register word).
  if (DATA_W < 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      LW > DATA_W || TIMEOUT_CYC < 1) begin : g_param_check
    $error("poc_fifo: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_WAIT_LO = 2'd2,
    S_WAIT_HI = 2'd3
  } state_t;

  state_t            state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  logic              mode;      // 1 = polling, 0 = interrupt
  logic              enable;
  logic [LW-1:0]     thresh;
  logic              overflow;
  logic              timeout;

  logic              wr_data;
  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_thresh;
  logic              flush;
  logic              empty;
  logic              full;
  logic              busy;
  logic              pop;
  logic              push_ok;
  logic              ovf_set;
  logic              tmo_fire;

  // STATUS word assembly; undefined bits read 0.
  function automatic logic [DATA_W-1:0] status_word(input logic emp,
                                                    input logic ful,
                                                    input logic ovf,
                                                    input logic bsy,
                                                    input logic tmo);
    logic [DATA_W-1:0] s;
    s    = '0;
    s[0] = emp;
    s[1] = ful;
    s[2] = ovf;
    s[3] = bsy;
    s[4] = tmo;
    s[7] = !ful;
    return s;
  endfunction

  // Register-port decode
  assign wr_data   = wr_en && (addr == A_DATA);
  assign wr_ctrl   = wr_en && (addr == A_CTRL);
  assign wr_status = wr_en && (addr == A_STATUS);
  assign wr_thresh = wr_en && (addr == A_THRESH);
  assign flush     = wr_ctrl && wdata[2];

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign busy  = (state != S_IDLE);

  // Fullness is judged before any same-cycle pop; a flush swallows the push
  // silently. (With a single address port, a flush and a DATA push cannot
  // coincide today, but the gating keeps the FIFO consistent if they ever do.)
  assign push_ok = wr_data && !full && !flush;
  assign ovf_set = wr_data &&  full && !flush;
  assign pop     = (state == S_IDLE) && enable && !empty && print_ready;

`ifdef POC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive cycle spent waiting on the printer.
  assign tmo_fire = ((state == S_WAIT_LO) || (state == S_WAIT_HI)) &&
                    (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_fire = 1'b0;
`endif

  // FIFO storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // FIFO pointers and level. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Control / threshold / sticky status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= 1'b0;
      enable   <= 1'b1;
      thresh   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        mode   <= wdata[0];
        enable <= wdata[1];
      end
      if (wr_thresh) begin
        thresh <= wdata[LW-1:0];
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (wr_status && wdata[2]) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef POC_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (tmo_fire) begin
      timeout <= 1'b1;
    end else if (wr_status && wdata[4]) begin
      timeout <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Printer-service FSM; print_data and pulse_request are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      print_data    <= '0;
      pulse_request <= 1'b0;
`ifdef POC_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      pulse_request <= 1'b0;
`ifdef POC_TIMEOUT_EN
      if (((state == S_WAIT_LO) || (state == S_WAIT_HI)) && !tmo_fire) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
`endif
      if (tmo_fire) begin
        // Abandon the byte; the printer never completed the handshake.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              print_data    <= mem[rd_ptr];
              pulse_request <= 1'b1;
              state         <= S_STROBE;
            end
          end
          S_STROBE: begin
            state <= S_WAIT_LO;
          end
          S_WAIT_LO: begin
            if (!print_ready) begin
              state <= S_WAIT_HI;
            end
          end
          S_WAIT_HI: begin
            if (print_ready) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Registered read port; on a simultaneous write the pre-write state is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      case (addr)
        A_DATA:   rdata <= DATA_W'(level);
        A_CTRL:   rdata <= DATA_W'({enable, mode});
        A_STATUS: rdata <= status_word(empty, full, overflow, busy, timeout);
        A_THRESH: rdata <= DATA_W'(thresh);
        default:  rdata <= '0;
      endcase
    end
  end

  // Interrupt: one cycle behind the level/threshold/overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b1;
    end else begin
      irq <= !((!mode && enable && (level <= thresh)) || overflow);
    end
  end

endmodule

// File: tb/tb_poc_fifo.sv
`timescale 1ns/1ps
module tb_poc_fifo;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 16;
  localparam int TIMEOUT_CYC = 8;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [1:0]        addr  = 2'd0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              irq;
  logic              print_ready;
  logic [DATA_W-1:0] print_data;
  logic              pulse_request;

  // Printer model: either a manual level or an auto-responder that drops
  // ready right after the strobe and raises it one cycle later.
  logic man_ready  = 1'b0;
  logic auto_on    = 1'b0;
  logic auto_ready = 1'b1;
  int   low_cnt    = 0;
  assign print_ready = auto_on ? auto_ready : man_ready;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: exp_print doubles as the reference FIFO contents.
  logic [DATA_W-1:0] exp_print [$];
  logic [DATA_W-1:0] exp_rd    [$];
  logic              rd_pend    = 1'b0;
  logic              pulse_prev = 1'b0;

  always #5 clk = ~clk;

  poc_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .irq          (irq),
    .print_ready  (print_ready),
    .print_data   (print_data),
    .pulse_request(pulse_request)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares read data and strobed bytes against the queues.
  always @(posedge clk) rd_pend <= rd_en;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_unexpected: got 0x%0h, expected no read", rdata);
      end else begin
        chk("read", rdata, exp_rd.pop_front());
      end
    end
    if (pulse_request === 1'b1) begin
      chk("strobe_width", pulse_prev, 0);
      if (exp_print.size() == 0) begin
        checks++; errors++;
        $display("FAIL strobe_unexpected: got 0x%0h, expected no strobe", print_data);
      end else begin
        chk("print_data", print_data, exp_print.pop_front());
      end
    end
    pulse_prev = pulse_request;
  end

  always @(negedge clk) begin
    if (pulse_request === 1'b1) begin
      auto_ready = 1'b0;
      low_cnt    = 1;
    end else if (low_cnt > 0) begin
      auto_ready = 1'b0;
      low_cnt    = low_cnt - 1;
    end else begin
      auto_ready = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [DATA_W-1:0] e);
    exp_rd.push_back(e);
    rd_en = 1'b1; addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  // Push with the FIFO not draining: accepted only while below DEPTH.
  task automatic model_push(input logic [DATA_W-1:0] d, inout bit ovf);
    if (exp_print.size() < DEPTH) exp_print.push_back(d);
    else ovf = 1'b1;
    wr(A_DATA, d);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_print.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    chk("drain_remaining", exp_print.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] fb [3];
    logic [DATA_W-1:0] st;
    bit                ovf;
    int                n;
    int                lvl;

    // Reset values
    #12;
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", irq, 1);
    chk("rst_print_data", print_data, 0);
    chk("rst_pulse", pulse_request, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("irq_hold_after_release", irq, 1);
    tick(1);
    chk("irq_low_after_reset", irq, 0);
    rd(A_STATUS, 8'h81);
    rd(A_CTRL, 8'h02);
    rd(A_THRESH, 8'h00);
    rd(A_DATA, 8'h00);

    // Polling mode, single byte, manual printer handshake
    wr(A_CTRL, 8'h03);
    man_ready = 1'b1;
    exp_print.push_back(8'hA5);
    wr(A_DATA, 8'hA5);
    chk("strobe_not_yet", pulse_request, 0);
    tick(1);
    chk("strobe_latency", pulse_request, 1);
    chk("strobe_data", print_data, 8'hA5);
    tick(1);
    chk("strobe_one_cycle", pulse_request, 0);
    rd(A_STATUS, 8'h89);
    man_ready = 1'b0;
    tick(1);
    rd(A_STATUS, 8'h89);
    man_ready = 1'b1;
    tick(1);
    rd(A_STATUS, 8'h81);
    chk("irq_polling_idle", irq, 1);

    // Overflow with printing disabled
    wr(A_CTRL, 8'h01);
    ovf = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) model_push(DATA_W'($urandom), ovf);
    chk("model_overflow", ovf, 1);
    rd(A_STATUS, 8'h06);
    rd(A_DATA, DATA_W'(DEPTH));
    chk("irq_overflow", irq, 0);
    wr(A_STATUS, 8'h04);
    tick(1);
    chk("irq_after_w1c", irq, 1);
    rd(A_STATUS, 8'h02);
    auto_on = 1'b1;
    wr(A_CTRL, 8'h03);
    wait_drain(DEPTH * 5 + 20);
    tick(6);
    rd(A_STATUS, 8'h81);

    // Interrupt mode low-water mark while draining
    wr(A_CTRL, 8'h00);
    wr(A_THRESH, 8'h02);
    rd(A_THRESH, 8'h02);
    ovf = 1'b0;
    for (int i = 0; i < 4; i++) model_push(DATA_W'($urandom), ovf);
    tick(2);
    chk("irq_disabled_masked", irq, 1);
    wr(A_CTRL, 8'h02);
    // Pops land 1, 5, 9, 13 edges after enable; level reaches 2 at edge 5.
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      chk($sformatf("irq_lwm_%0d", i), irq, (i <= 5) ? 1 : 0);
    end
    wait_drain(40);
    tick(6);
    rd(A_STATUS, 8'h81);
    chk("irq_empty_int_mode", irq, 0);

    // Flush coinciding with a pop: the popped byte still strobes
    auto_on   = 1'b0;
    man_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fb[i] = DATA_W'($urandom);
      wr(A_DATA, fb[i]);
    end
    rd(A_DATA, 8'h03);
    man_ready = 1'b1;
    exp_print.push_back(fb[0]);
    wr(A_CTRL, 8'h06);
    chk("flush_strobe", pulse_request, 1);
    chk("flush_strobe_data", print_data, fb[0]);
    rd(A_DATA, 8'h00);
    rd(A_STATUS, 8'h89);
    man_ready = 1'b0;
    tick(1);
    man_ready = 1'b1;
    tick(3);
    rd(A_STATUS, 8'h81);
    rd(A_CTRL, 8'h02);

    // Randomized rounds: fill (with occasional flush), check, drain
    auto_on = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wr(A_CTRL, 8'h01);
      ovf = 1'b0;
      n = $urandom_range(0, DEPTH + 3);
      for (int i = 0; i < n; i++) begin
        b = DATA_W'($urandom);
        if ($urandom_range(0, 15) == 0) begin
          wr(A_CTRL, 8'h05);
          exp_print.delete();
        end
        model_push(b, ovf);
      end
      lvl = exp_print.size();
      rd(A_DATA, DATA_W'(lvl));
      st    = '0;
      st[0] = (lvl == 0);
      st[1] = (lvl == DEPTH);
      st[2] = ovf;
      st[7] = (lvl != DEPTH);
      rd(A_STATUS, st);
      chk("rand_irq", irq, !ovf);
      wr(A_STATUS, 8'h04);
      wr(A_CTRL, 8'h03);
      wait_drain(DEPTH * 5 + 20);
      tick(6);
      rd(A_DATA, 8'h00);
    end

`ifdef POC_TIMEOUT_EN
    // Printer stuck high after the strobe: watchdog returns the FSM to IDLE
    auto_on   = 1'b0;
    man_ready = 1'b1;
    b = DATA_W'($urandom);
    exp_print.push_back(b);
    wr(A_DATA, b);
    tick(2);
    tick(7);
    rd(A_STATUS, 8'h89);
    rd(A_STATUS, 8'h91);
    wr(A_STATUS, 8'h10);
    rd(A_STATUS, 8'h81);
`else
    // No watchdog: timeout bit stays 0 and its W1C write is harmless
    wr(A_STATUS, 8'h10);
    rd(A_STATUS, 8'h81);
`endif

    tick(4);
    chk("reads_outstanding", exp_rd.size(), 0);
    chk("prints_outstanding", exp_print.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
